// File: rtl/xor_frame_accumulator_if.sv
// Stream bundle for xor_frame_accumulator: input word side and folded-result side.
interface xor_frame_accumulator_if #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_LEN = 16
);
  localparam int unsigned CW = $clog2(MAX_LEN + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_parity;
  logic [CW-1:0]    out_count;
  logic             out_overflow;

  // Block side: consumes words, produces results.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_parity, out_count, out_overflow
  );

  // Environment side: produces words, consumes results.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_parity, out_count, out_overflow
  );
endinterface

// File: rtl/xor_frame_accumulator.sv
// Folds a frame of WIDTH-bit words into one XOR result with parity, word count and
// overflow flag. One result buffer; words past MAX_LEN are drained up to in_last.
module xor_frame_accumulator #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_LEN = 16,
  parameter bit          ODD     = 1'b0
) (
  input logic                    clk,
  input logic                    rst,
  xor_frame_accumulator_if.slave bus
);
  localparam int unsigned CW = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {StAcc, StHold, StDrain} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             drain_q, drain_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_parity_q, out_parity_d;
  logic [CW-1:0]    out_count_q, out_count_d;
  logic             out_overflow_q, out_overflow_d;

  logic             in_ready;
  logic             accept;
  logic [WIDTH-1:0] acc_n;
  logic [CW-1:0]    cnt_n;
  logic             full_n;

  // Input is taken in ACC and DRAIN; HOLD stalls until the result is consumed.
  always_comb begin
    in_ready = (state_q == StAcc) || (state_q == StDrain);
    accept   = bus.in_valid && in_ready;
    // First word of a frame loads rather than folds, so acc need not be cleared early.
    acc_n    = (cnt_q == '0) ? bus.in_data : (acc_q ^ bus.in_data);
    cnt_n    = cnt_q + CW'(1);
    full_n   = (cnt_n == CW'(MAX_LEN));
  end

  // Next-state and result-buffer update.
  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    drain_d        = drain_q;
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    out_parity_d   = out_parity_q;
    out_count_d    = out_count_q;
    out_overflow_d = out_overflow_q;
    unique case (state_q)
      StAcc: begin
        if (accept) begin
          if (bus.in_last || full_n) begin
            out_data_d     = acc_n;
            out_count_d    = cnt_n;
            out_parity_d   = ODD ? ~^acc_n : ^acc_n;
            out_overflow_d = full_n && !bus.in_last;
            drain_d        = full_n && !bus.in_last;
            out_valid_d    = 1'b1;
            acc_d          = '0;
            cnt_d          = '0;
            state_d        = StHold;
          end else begin
            acc_d = acc_n;
            cnt_d = cnt_n;
          end
        end
      end
      StHold: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          drain_d     = 1'b0;
          state_d     = drain_q ? StDrain : StAcc;
        end
      end
      StDrain: begin
        // Overflow words are dropped; acc/cnt already cleared at close.
        if (accept && bus.in_last) begin
          state_d = StAcc;
        end
      end
      default: state_d = StAcc;
    endcase
  end

  // State and result registers; reset discards any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StAcc;
      acc_q          <= '0;
      cnt_q          <= '0;
      drain_q        <= 1'b0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_parity_q   <= 1'b0;
      out_count_q    <= '0;
      out_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      drain_q        <= drain_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_parity_q   <= out_parity_d;
      out_count_q    <= out_count_d;
      out_overflow_q <= out_overflow_d;
    end
  end

  // Drive the bundle from registered state.
  always_comb begin
    bus.in_ready     = in_ready;
    bus.out_valid    = out_valid_q;
    bus.out_data     = out_data_q;
    bus.out_parity   = out_parity_q;
    bus.out_count    = out_count_q;
    bus.out_overflow = out_overflow_q;
  end
endmodule

// File: tb/tb_xor_frame_accumulator.sv
// Directed bench: dut_a (MAX_LEN=4, even parity) and dut_b (MAX_LEN=16, odd parity).
module tb_xor_frame_accumulator;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid, in_last, out_ready, sel;
  logic [7:0] in_data;

  xor_frame_accumulator_if #(.WIDTH(8), .MAX_LEN(4))  ifa ();
  xor_frame_accumulator_if #(.WIDTH(8), .MAX_LEN(16)) ifb ();

  assign ifa.in_valid  = in_valid && !sel;
  assign ifa.in_data   = in_data;
  assign ifa.in_last   = in_last;
  assign ifa.out_ready = out_ready && !sel;
  assign ifb.in_valid  = in_valid && sel;
  assign ifb.in_data   = in_data;
  assign ifb.in_last   = in_last;
  assign ifb.out_ready = out_ready && sel;

  xor_frame_accumulator #(.WIDTH(8), .MAX_LEN(4), .ODD(1'b0)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );
  xor_frame_accumulator #(.WIDTH(8), .MAX_LEN(16), .ODD(1'b1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  logic       cur_in_ready, cur_valid, cur_parity, cur_ovf;
  logic [7:0] cur_data;
  logic [4:0] cur_count;
  assign cur_in_ready = sel ? ifb.in_ready     : ifa.in_ready;
  assign cur_valid    = sel ? ifb.out_valid    : ifa.out_valid;
  assign cur_parity   = sel ? ifb.out_parity   : ifa.out_parity;
  assign cur_ovf      = sel ? ifb.out_overflow : ifa.out_overflow;
  assign cur_data     = sel ? ifb.out_data     : ifa.out_data;
  assign cur_count    = sel ? ifb.out_count    : {2'b00, ifa.out_count};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Offer one word and return #1 after the edge that accepts it.
  task automatic send_word(input logic [7:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!cur_in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cur_in_ready) check("accept_timeout", 32'(cur_in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 'x;
    in_last  = 'x;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [7:0] d, input logic p,
                              input logic [4:0] c, input logic o);
    check({tag, "_valid"}, 32'(cur_valid), 32'd1);
    check({tag, "_data"},  32'(cur_data), 32'(d));
    check({tag, "_par"},   32'(cur_parity), 32'(p));
    check({tag, "_count"}, 32'(cur_count), 32'(c));
    check({tag, "_ovf"},   32'(cur_ovf), 32'(o));
    check({tag, "_inrdy"}, 32'(cur_in_ready), 32'd0);
  endtask

  typedef struct {
    bit          s;
    int          n;
    logic [47:0] w;     // word i at w[8*i +: 8]
    logic        le;    // in_last on final word
    logic [7:0]  d;
    logic        p;
    logic [4:0]  c;
    logic        o;
  } vec_t;

  function automatic vec_t mk(bit s, int n, logic [47:0] w, logic le, logic [7:0] d,
                              logic p, logic [4:0] c, logic o);
    vec_t v;
    v.s = s; v.n = n; v.w = w; v.le = le; v.d = d; v.p = p; v.c = c; v.o = o;
    return v;
  endfunction

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(0, 3, 48'h3CF00F, 1, 8'hC3, 0, 3, 0);
    vecs[1] = mk(0, 1, 48'h01, 1, 8'h01, 1, 1, 0);
    vecs[2] = mk(0, 4, 48'h88442211, 1, 8'hFF, 0, 4, 0);   // last on MAX_LEN-th word
    vecs[3] = mk(0, 2, 48'h5AA5, 1, 8'hFF, 0, 2, 0);
    vecs[4] = mk(0, 2, 48'h0007, 1, 8'h07, 1, 2, 0);
    vecs[5] = mk(1, 3, 48'h3CF00F, 1, 8'hC3, 1, 3, 0);
    vecs[6] = mk(1, 1, 48'h01, 1, 8'h01, 0, 1, 0);
    vecs[7] = mk(1, 6, 48'h060504030201, 1, 8'h07, 0, 6, 0);

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0; sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(cur_valid), 32'd0);
    check("rst_data",  32'(cur_data), 32'd0);
    check("rst_count", 32'(cur_count), 32'd0);
    check("rst_ovf",   32'(cur_ovf), 32'd0);
    check("rst_par",   32'(cur_parity), 32'd0);
    check("rst_inrdy", 32'(cur_in_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      sel = vecs[i].s;
      for (int k = 0; k < vecs[i].n; k++) begin
        send_word(vecs[i].w[8*k +: 8], (k == vecs[i].n - 1) ? vecs[i].le : 1'b0);
        if (k < vecs[i].n - 1) check($sformatf("v%0d_early", i), 32'(cur_valid), 32'd0);
      end
      check_result($sformatf("v%0d", i), vecs[i].d, vecs[i].p, vecs[i].c, vecs[i].o);
      handshake();
      check($sformatf("v%0d_drop", i), 32'(cur_valid), 32'd0);
      check($sformatf("v%0d_rdy", i), 32'(cur_in_ready), 32'd1);
    end

    // Backpressure: result must hold and input must stall while a word is offered.
    sel = 1'b0;
    send_word(8'h3C, 1'b0);
    send_word(8'h81, 1'b1);
    in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 32'(cur_valid), 32'd1);
      check("bp_data",  32'(cur_data), 32'hBD);
      check("bp_count", 32'(cur_count), 32'd2);
      check("bp_inrdy", 32'(cur_in_ready), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    handshake();
    check("bp_drop",  32'(cur_valid), 32'd0);
    check("bp_rdy",   32'(cur_in_ready), 32'd1);
    check("bp_keep",  32'(cur_data), 32'hBD);

    // Overflow on MAX_LEN=4, then drain up to in_last.
    send_word(8'h01, 1'b0);
    send_word(8'h02, 1'b0);
    send_word(8'h03, 1'b0);
    send_word(8'h04, 1'b0);
    check_result("ovf", 8'h04, 1'b1, 5'd4, 1'b1);
    handshake();
    check("ovf_drop", 32'(cur_valid), 32'd0);
    send_word(8'h05, 1'b0);
    check("drain1_valid", 32'(cur_valid), 32'd0);
    send_word(8'h06, 1'b1);
    check("drain2_valid", 32'(cur_valid), 32'd0);
    check("drain2_count", 32'(cur_count), 32'd4);
    check("drain2_rdy",   32'(cur_in_ready), 32'd1);
    send_word(8'hAA, 1'b1);
    check_result("post", 8'hAA, 1'b0, 5'd1, 1'b0);
    handshake();

    // Async reset with a partial frame pending.
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    #3 rst = 1'b1;
    #1;
    check("arst_data",  32'(cur_data), 32'd0);
    check("arst_count", 32'(cur_count), 32'd0);
    check("arst_valid", 32'(cur_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send_word(8'h55, 1'b1);
    check_result("rst_frame", 8'h55, 1'b0, 5'd1, 1'b0);
    handshake();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
